// File: rtl/axi_lite_req_arbiter.sv
// axi_lite_req_arbiter
// Shares the single command port of axi_lite_master between two clients.
// One command is in flight at a time. The arbiter latches the granted
// command, issues a one-cycle request to the master, waits for the matching
// done pulse, and then pulses done back to the granted client only.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate between the clients. When it is undefined, s0 has fixed
// priority.
module axi_lite_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  // client 0
  input  logic                    s0_req,
  input  logic                    s0_we,
  input  logic [ADDR_WIDTH-1:0]   s0_addr,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  output logic                    s0_done,
  output logic [1:0]              s0_resp,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  // client 1
  input  logic                    s1_req,
  input  logic                    s1_we,
  input  logic [ADDR_WIDTH-1:0]   s1_addr,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  output logic                    s1_done,
  output logic [1:0]              s1_resp,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  // master write command port
  output logic                    m_wr_req,
  output logic [ADDR_WIDTH-1:0]   m_wr_addr,
  output logic [DATA_WIDTH-1:0]   m_wr_data,
  output logic [DATA_WIDTH/8-1:0] m_wr_strb,
  input  logic                    m_wr_done,
  input  logic [1:0]              m_wr_resp,
  // master read command port
  output logic                    m_rd_req,
  output logic [ADDR_WIDTH-1:0]   m_rd_addr,
  input  logic                    m_rd_done,
  input  logic [1:0]              m_rd_resp,
  input  logic [DATA_WIDTH-1:0]   m_rd_data,
  // status
  output logic                    busy,
  output logic                    grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_grant;
  logic                    r_last;
  logic                    r_busy;
  logic                    r_wr_req;
  logic                    r_rd_req;
  logic                    r_s0_done;
  logic                    r_s1_done;
  logic [1:0]              r_s0_resp;
  logic [1:0]              r_s1_resp;
  logic [DATA_WIDTH-1:0]   r_s0_rdata;
  logic [DATA_WIDTH-1:0]   r_s1_rdata;

  logic                    w_any_req;
  logic                    w_sel;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH/8-1:0] w_wstrb;
  logic                    w_m_done;
  logic [1:0]              w_cap_resp;
  logic [DATA_WIDTH-1:0]   w_cap_data;

  assign w_any_req = s0_req | s1_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, favour the client that was not served last.
  assign w_sel = (s0_req & s1_req) ? ~r_last : ~s0_req;
`else
  // s0 wins every tie; s1 is chosen only when s0 is not requesting.
  assign w_sel = ~s0_req;
`endif

  assign w_we    = w_sel ? s1_we    : s0_we;
  assign w_addr  = w_sel ? s1_addr  : s0_addr;
  assign w_wdata = w_sel ? s1_wdata : s0_wdata;
  assign w_wstrb = w_sel ? s1_wstrb : s0_wstrb;

  // Only the done that matches the latched direction counts. A stray done on
  // the other channel is ignored.
  assign w_m_done   = r_we ? m_wr_done : m_rd_done;
  assign w_cap_resp = r_we ? m_wr_resp : m_rd_resp;
  assign w_cap_data = r_we ? '0 : m_rd_data;

  // Next-state logic for the command sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_m_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Command latch, master request pulses, response capture and client done pulses
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_busy     <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_req   <= 1'b0;
      r_s0_done  <= 1'b0;
      r_s1_done  <= 1'b0;
      r_s0_resp  <= 2'b00;
      r_s1_resp  <= 2'b00;
      r_s0_rdata <= '0;
      r_s1_rdata <= '0;
    end else begin
      r_wr_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_s0_done <= 1'b0;
      r_s1_done <= 1'b0;
      r_busy    <= (w_next != S_IDLE);
      if (r_state == S_IDLE && w_any_req) begin
        r_grant  <= w_sel;
        r_we     <= w_we;
        r_addr   <= w_addr;
        r_wdata  <= w_wdata;
        r_wstrb  <= w_wstrb;
        r_wr_req <= w_we;
        r_rd_req <= ~w_we;
      end
      if (r_state == S_WAIT && w_m_done) begin
        if (r_grant) begin
          r_s1_done  <= 1'b1;
          r_s1_resp  <= w_cap_resp;
          r_s1_rdata <= w_cap_data;
        end else begin
          r_s0_done  <= 1'b1;
          r_s0_resp  <= w_cap_resp;
          r_s0_rdata <= w_cap_data;
        end
      end
      if (r_state == S_DONE) r_last <= r_grant;
    end
  end

  assign s0_done   = r_s0_done;
  assign s0_resp   = r_s0_resp;
  assign s0_rdata  = r_s0_rdata;
  assign s1_done   = r_s1_done;
  assign s1_resp   = r_s1_resp;
  assign s1_rdata  = r_s1_rdata;
  assign m_wr_req  = r_wr_req;
  assign m_wr_addr = r_addr;
  assign m_wr_data = r_wdata;
  assign m_wr_strb = r_wstrb;
  assign m_rd_req  = r_rd_req;
  assign m_rd_addr = r_addr;
  assign busy      = r_busy;
  assign grant_id  = r_grant;

endmodule
